mips_instruction_decode: RTL and testbench

// - MIPS32 pipeline ID stage: splits the instruction into fields and generates control.
// - Holds the 32x32 register file; the WB stage writes it back.
// - All outputs are registered into the ID/EX boundary: IF/ID feeds it, EX consumes it.

---
 rtl/mips_instruction_decode.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_mips_instruction_decode.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/mips_instruction_decode.sv
// rtl/mips_instruction_decode.sv - MIPS32 ID stage: field split, control decode, 32x32 register file (optional ID_WB_BYPASS_EN)
module mips_instruction_decode #(
    parameter int NB_DATA = 32,
    parameter int NB_REG  = 5
) (
    input  logic               clk,
    input  logic               i_rst_n,
    input  logic [31:0]        i_instruction,
    input  logic [31:0]        i_pcounter4,
    input  logic               i_we_wb,
    input  logic               i_we,
    input  logic [NB_REG-1:0]  i_wr_addr,
    input  logic [NB_DATA-1:0] i_wr_data_WB,
    input  logic               i_stall,
    output logic [NB_REG-1:0]  o_rs,
    output logic [NB_REG-1:0]  o_rt,
    output logic [NB_REG-1:0]  o_rd,
    output logic [4:0]         o_shamt,
    output logic [5:0]         o_opcode,
    output logic [5:0]         o_func,
    output logic [15:0]        o_addr,
    output logic [NB_DATA-1:0] o_reg_DA,
    output logic [NB_DATA-1:0] o_reg_DB,
    output logic [NB_DATA-1:0] o_immediate,
    output logic               o_jump,
    output logic               o_branch,
    output logic               o_regDst,
    output logic               o_mem2Reg,
    output logic               o_memRead,
    output logic               o_memWrite,
    output logic               o_immediat,
    output logic               o_regWrite,
    output logic [1:0]         o_aluSrc,
    output logic [1:0]         o_aluOp
);

    localparam int NUM_REGS = 1 << NB_REG;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LH    = 6'b100001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LBU   = 6'b100100;
    localparam logic [5:0] OP_LHU   = 6'b100101;
    localparam logic [5:0] OP_LWU   = 6'b100111;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_SH    = 6'b101001;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SRL   = 6'b000010;
    localparam logic [5:0] FN_SRA   = 6'b000011;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_JALR  = 6'b001001;

    // Control vector layout, MSB first:
    // jump, branch, regDst, mem2Reg, memRead, memWrite, immediat, regWrite, aluSrc[1:0], aluOp[1:0]
    localparam int C_JUMP   = 11;
    localparam int C_BRANCH = 10;
    localparam int C_REGDST = 9;
    localparam int C_MEM2RG = 8;
    localparam int C_MEMRD  = 7;
    localparam int C_MEMWR  = 6;
    localparam int C_IMMED  = 5;
    localparam int C_REGWR  = 4;

    // Raw instruction fields
    logic [5:0]  instr_op;
    logic [5:0]  instr_fn;
    logic [15:0] instr_imm;
    assign instr_op  = i_instruction[31:26];
    assign instr_fn  = i_instruction[5:0];
    assign instr_imm = i_instruction[15:0];

    // Only the top nibble of PC+4 feeds the jump target
    logic unused_pc_low;
    assign unused_pc_low = ^i_pcounter4[27:0];

    // Register file and ID/EX boundary state
    logic [NB_DATA-1:0] regs_q [NUM_REGS];
    logic [NB_DATA-1:0] regs_d [NUM_REGS];

    logic [NB_REG-1:0]  rs_d, rs_q;
    logic [NB_REG-1:0]  rt_d, rt_q;
    logic [NB_REG-1:0]  rd_d, rd_q;
    logic [4:0]         shamt_d, shamt_q;
    logic [5:0]         opcode_d, opcode_q;
    logic [5:0]         func_d, func_q;
    logic [15:0]        addr_d, addr_q;
    logic [NB_DATA-1:0] reg_da_d, reg_da_q;
    logic [NB_DATA-1:0] reg_db_d, reg_db_q;
    logic [NB_DATA-1:0] imm_d, imm_q;
    logic [11:0]        ctrl_dec;
    logic [11:0]        ctrl_d, ctrl_q;

    logic wr_en;
    assign wr_en = i_we & i_we_wb & (i_wr_addr != '0);

    // Field extraction: R-type, J-type, otherwise I-type layout
    always_comb begin
        rs_d     = '0;
        rt_d     = '0;
        rd_d     = '0;
        shamt_d  = '0;
        func_d   = '0;
        addr_d   = '0;
        imm_d    = '0;
        opcode_d = instr_op;
        case (instr_op)
            OP_RTYPE: begin
                rs_d    = i_instruction[25:21];
                rt_d    = i_instruction[20:16];
                rd_d    = i_instruction[15:11];
                shamt_d = i_instruction[10:6];
                func_d  = instr_fn;
            end
            OP_J, OP_JAL: begin
                rd_d  = (instr_op == OP_JAL) ? NB_REG'(31) : '0;
                imm_d = {i_pcounter4[31:28], i_instruction[25:0], 2'b00};
            end
            default: begin
                rs_d   = i_instruction[25:21];
                rt_d   = i_instruction[20:16];
                addr_d = instr_imm;
                if (instr_op == OP_ANDI || instr_op == OP_ORI || instr_op == OP_XORI) begin
                    imm_d = {{(NB_DATA-16){1'b0}}, instr_imm};
                end else begin
                    imm_d = {{(NB_DATA-16){instr_imm[15]}}, instr_imm};
                end
            end
        endcase
    end

    // Main control decode; unknown opcodes decode as NOP
    always_comb begin
        ctrl_dec = '0;
        case (instr_op)
            OP_RTYPE: begin
                ctrl_dec[C_REGDST] = 1'b1;
                ctrl_dec[C_REGWR]  = 1'b1;
                ctrl_dec[1:0]      = 2'b10;
                if (instr_fn == FN_SLL || instr_fn == FN_SRL || instr_fn == FN_SRA) begin
                    ctrl_dec[3:2] = 2'b01;
                end
                if (instr_fn == FN_JR) begin
                    ctrl_dec[C_JUMP]  = 1'b1;
                    ctrl_dec[C_REGWR] = 1'b0;
                end
                if (instr_fn == FN_JALR) begin
                    ctrl_dec[C_JUMP] = 1'b1;
                end
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                ctrl_dec[C_IMMED] = 1'b1;
                ctrl_dec[C_REGWR] = 1'b1;
                ctrl_dec[3:2]     = 2'b10;
                ctrl_dec[1:0]     = 2'b11;
            end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_LWU: begin
                ctrl_dec[C_MEMRD]  = 1'b1;
                ctrl_dec[C_MEM2RG] = 1'b1;
                ctrl_dec[C_REGWR]  = 1'b1;
                ctrl_dec[3:2]      = 2'b10;
            end
            OP_SB, OP_SH, OP_SW: begin
                ctrl_dec[C_MEMWR] = 1'b1;
                ctrl_dec[3:2]     = 2'b10;
            end
            OP_BEQ, OP_BNE: begin
                ctrl_dec[C_BRANCH] = 1'b1;
                ctrl_dec[1:0]      = 2'b01;
            end
            OP_J: begin
                ctrl_dec[C_JUMP] = 1'b1;
            end
            OP_JAL: begin
                ctrl_dec[C_JUMP]  = 1'b1;
                ctrl_dec[C_REGWR] = 1'b1;
            end
            default: ctrl_dec = '0;
        endcase
        // A stall turns this slot into a bubble; fields keep flowing
        ctrl_d = i_stall ? 12'b0 : ctrl_dec;
    end

    // Register file next state and operand read ($0 hard-wired to zero)
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (wr_en) begin
            regs_d[i_wr_addr] = i_wr_data_WB;
        end
        reg_da_d = (rs_d == '0) ? '0 : regs_q[rs_d];
        reg_db_d = (rt_d == '0) ? '0 : regs_q[rt_d];
`ifdef ID_WB_BYPASS_EN
        // Same-edge WB forwarding so EX sees the value being written now
        if (wr_en && i_wr_addr == rs_d) begin
            reg_da_d = i_wr_data_WB;
        end
        if (wr_en && i_wr_addr == rt_d) begin
            reg_db_d = i_wr_data_WB;
        end
`endif
    end

    // Register file storage; reset clears every entry
    always_ff @(posedge clk) begin
        if (i_rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // ID/EX boundary registers; reset takes priority over stall and write
    always_ff @(posedge clk) begin
        if (i_rst_n) begin
            rs_q     <= '0;
            rt_q     <= '0;
            rd_q     <= '0;
            shamt_q  <= '0;
            opcode_q <= '0;
            func_q   <= '0;
            addr_q   <= '0;
            reg_da_q <= '0;
            reg_db_q <= '0;
            imm_q    <= '0;
            ctrl_q   <= '0;
        end else begin
            rs_q     <= rs_d;
            rt_q     <= rt_d;
            rd_q     <= rd_d;
            shamt_q  <= shamt_d;
            opcode_q <= opcode_d;
            func_q   <= func_d;
            addr_q   <= addr_d;
            reg_da_q <= reg_da_d;
            reg_db_q <= reg_db_d;
            imm_q    <= imm_d;
            ctrl_q   <= ctrl_d;
        end
    end

    assign o_rs        = rs_q;
    assign o_rt        = rt_q;
    assign o_rd        = rd_q;
    assign o_shamt     = shamt_q;
    assign o_opcode    = opcode_q;
    assign o_func      = func_q;
    assign o_addr      = addr_q;
    assign o_reg_DA    = reg_da_q;
    assign o_reg_DB    = reg_db_q;
    assign o_immediate = imm_q;
    assign o_jump      = ctrl_q[C_JUMP];
    assign o_branch    = ctrl_q[C_BRANCH];
    assign o_regDst    = ctrl_q[C_REGDST];
    assign o_mem2Reg   = ctrl_q[C_MEM2RG];
    assign o_memRead   = ctrl_q[C_MEMRD];
    assign o_memWrite  = ctrl_q[C_MEMWR];
    assign o_immediat  = ctrl_q[C_IMMED];
    assign o_regWrite  = ctrl_q[C_REGWR];
    assign o_aluSrc    = ctrl_q[3:2];
    assign o_aluOp     = ctrl_q[1:0];

endmodule

// File: tb/tb_mips_instruction_decode.sv
// tb/tb_mips_instruction_decode.sv - scoreboard bench for mips_instruction_decode
module tb_mips_instruction_decode;

    logic        clk;
    logic        i_rst_n;
    logic [31:0] i_instruction;
    logic [31:0] i_pcounter4;
    logic        i_we_wb;
    logic        i_we;
    logic [4:0]  i_wr_addr;
    logic [31:0] i_wr_data_WB;
    logic        i_stall;
    logic [4:0]  o_rs, o_rt, o_rd, o_shamt;
    logic [5:0]  o_opcode, o_func;
    logic [15:0] o_addr;
    logic [31:0] o_reg_DA, o_reg_DB, o_immediate;
    logic        o_jump, o_branch, o_regDst, o_mem2Reg, o_memRead, o_memWrite, o_immediat, o_regWrite;
    logic [1:0]  o_aluSrc, o_aluOp;

    mips_instruction_decode #(.NB_DATA(32), .NB_REG(5)) dut (
        .clk(clk), .i_rst_n(i_rst_n), .i_instruction(i_instruction), .i_pcounter4(i_pcounter4),
        .i_we_wb(i_we_wb), .i_we(i_we), .i_wr_addr(i_wr_addr), .i_wr_data_WB(i_wr_data_WB),
        .i_stall(i_stall), .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd), .o_shamt(o_shamt),
        .o_opcode(o_opcode), .o_func(o_func), .o_addr(o_addr), .o_reg_DA(o_reg_DA),
        .o_reg_DB(o_reg_DB), .o_immediate(o_immediate), .o_jump(o_jump), .o_branch(o_branch),
        .o_regDst(o_regDst), .o_mem2Reg(o_mem2Reg), .o_memRead(o_memRead), .o_memWrite(o_memWrite),
        .o_immediat(o_immediat), .o_regWrite(o_regWrite), .o_aluSrc(o_aluSrc), .o_aluOp(o_aluOp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [47:0] q_f[$];
    logic [95:0] q_d[$];
    logic [11:0] q_c[$];
    string       q_n[$];

    function automatic logic [47:0] fld(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                                        input logic [15:0] ad);
        return {op, rs, rt, rd, sh, fn, ad};
    endfunction

    // Drive one instruction slot on the falling edge and queue its expected ID/EX contents
    task automatic step(input logic rst, input logic [31:0] instr, input logic [31:0] pc4,
                        input logic we, input logic we_wb, input logic [4:0] waddr,
                        input logic [31:0] wdata, input logic stall,
                        input logic [47:0] ef, input logic [95:0] ed, input logic [11:0] ec,
                        input string nm);
        @(negedge clk);
        i_rst_n       = rst;
        i_instruction = instr;
        i_pcounter4   = pc4;
        i_we          = we;
        i_we_wb       = we_wb;
        i_wr_addr     = waddr;
        i_wr_data_WB  = wdata;
        i_stall       = stall;
        q_f.push_back(ef);
        q_d.push_back(ed);
        q_c.push_back(ec);
        q_n.push_back(nm);
    endtask

    // Monitor: one registered result per edge after a slot was issued
    always @(posedge clk) begin
        logic [47:0] af;
        logic [95:0] ad;
        logic [11:0] ac;
        logic [47:0] ef;
        logic [95:0] ed;
        logic [11:0] ec;
        string       nm;
        #1;
        if (q_f.size() > 0) begin
            ef = q_f.pop_front();
            ed = q_d.pop_front();
            ec = q_c.pop_front();
            nm = q_n.pop_front();
            af = {o_opcode, o_rs, o_rt, o_rd, o_shamt, o_func, o_addr};
            ad = {o_reg_DA, o_reg_DB, o_immediate};
            ac = {o_jump, o_branch, o_regDst, o_mem2Reg, o_memRead, o_memWrite, o_immediat, o_regWrite, o_aluSrc, o_aluOp};
            n_cmp++;
            if (af !== ef) begin
                n_bad++;
                $display("FAIL %s fields: got %h want %h", nm, af, ef);
            end
            n_cmp++;
            if (ad !== ed) begin
                n_bad++;
                $display("FAIL %s data: got %h want %h", nm, ad, ed);
            end
            n_cmp++;
            if (ac !== ec) begin
                n_bad++;
                $display("FAIL %s ctrl: got %h want %h", nm, ac, ec);
            end
        end
    end

    localparam logic [31:0] ADD123 = 32'h0022_1820;
    localparam logic [31:0] DEAD   = 32'hDEAD_BEEF;
    localparam logic [31:0] CAFE   = 32'hCAFE_F00D;
    localparam logic [31:0] LW     = 32'h8C22_FFFC;

    initial begin
        logic [47:0] f_add;
        logic [31:0] byp_a;
        logic [31:0] byp_b;
        f_add = fld(6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0);
`ifdef ID_WB_BYPASS_EN
        byp_a = DEAD;
        byp_b = CAFE;
`else
        byp_a = 32'h0;
        byp_b = 32'h0;
`endif
        i_rst_n = 1'b1; i_instruction = '0; i_pcounter4 = '0; i_we = 1'b0;
        i_we_wb = 1'b0; i_wr_addr = '0; i_wr_data_WB = '0; i_stall = 1'b0;

        step(1, ADD123, 0, 0, 0, 0, 0, 0, 48'h0, 96'h0, 12'h000, "reset");
        step(0, ADD123, 0, 0, 0, 0, 0, 0, f_add, 96'h0, 12'h212, "add");
        step(0, 32'h2022_0004, 0, 0, 0, 0, 0, 0, fld(6'h08, 1, 2, 0, 0, 0, 16'h0004),
             {32'h0, 32'h0, 32'h4}, 12'h03B, "addi");
        step(0, 32'h0800_0010, 32'h4, 0, 0, 0, 0, 0, fld(6'h02, 0, 0, 0, 0, 0, 0),
             {32'h0, 32'h0, 32'h40}, 12'h800, "j");
        step(0, 32'h0C00_0010, 32'h4000_0004, 0, 0, 0, 0, 0, fld(6'h03, 0, 0, 31, 0, 0, 0),
             {32'h0, 32'h0, 32'h4000_0040}, 12'h810, "jal");
        step(0, ADD123, 0, 1, 1, 5'd1, DEAD, 0, f_add, {byp_a, 32'h0, 32'h0}, 12'h212, "wr_r1");
        step(0, ADD123, 0, 0, 0, 0, 0, 0, f_add, {DEAD, 32'h0, 32'h0}, 12'h212, "rd_r1");
        step(0, 32'h0000_1820, 0, 1, 1, 5'd0, 32'h5, 0, fld(6'h00, 0, 0, 3, 0, 6'h20, 0),
             96'h0, 12'h212, "wr_r0");
        step(0, 32'h0000_1820, 0, 0, 0, 0, 0, 0, fld(6'h00, 0, 0, 3, 0, 6'h20, 0),
             96'h0, 12'h212, "rd_r0");
        step(0, ADD123, 0, 0, 1, 5'd2, 32'h1234_5678, 0, f_add, {DEAD, 32'h0, 32'h0}, 12'h212, "we_off");
        step(0, ADD123, 0, 1, 0, 5'd2, 32'h1234_5678, 0, f_add, {DEAD, 32'h0, 32'h0}, 12'h212, "wewb_off");
        step(0, ADD123, 0, 1, 1, 5'd2, CAFE, 0, f_add, {DEAD, byp_b, 32'h0}, 12'h212, "wr_r2");
        step(0, ADD123, 0, 0, 0, 0, 0, 0, f_add, {DEAD, CAFE, 32'h0}, 12'h212, "rd_r2");
        step(0, LW, 0, 0, 0, 0, 0, 1, fld(6'h23, 1, 2, 0, 0, 0, 16'hFFFC),
             {DEAD, CAFE, 32'hFFFF_FFFC}, 12'h000, "lw_stall");
        step(0, LW, 0, 0, 0, 0, 0, 0, fld(6'h23, 1, 2, 0, 0, 0, 16'hFFFC),
             {DEAD, CAFE, 32'hFFFF_FFFC}, 12'h198, "lw");
        step(0, 32'h3022_FFFC, 0, 0, 0, 0, 0, 0, fld(6'h0C, 1, 2, 0, 0, 0, 16'hFFFC),
             {DEAD, CAFE, 32'h0000_FFFC}, 12'h03B, "andi");
        step(0, 32'hAC22_FFFC, 0, 0, 0, 0, 0, 0, fld(6'h2B, 1, 2, 0, 0, 0, 16'hFFFC),
             {DEAD, CAFE, 32'hFFFF_FFFC}, 12'h048, "sw");
        step(0, 32'h1022_0003, 0, 0, 0, 0, 0, 0, fld(6'h04, 1, 2, 0, 0, 0, 16'h0003),
             {DEAD, CAFE, 32'h3}, 12'h401, "beq");
        step(0, 32'h0002_1080, 0, 0, 0, 0, 0, 0, fld(6'h00, 0, 2, 2, 2, 6'h00, 0),
             {32'h0, CAFE, 32'h0}, 12'h216, "sll");
        step(0, 32'hFC22_FFFC, 0, 0, 0, 0, 0, 0, fld(6'h3F, 1, 2, 0, 0, 0, 16'hFFFC),
             {DEAD, CAFE, 32'hFFFF_FFFC}, 12'h000, "unknown");
        step(0, ADD123, 0, 0, 0, 0, 0, 1, f_add, {DEAD, CAFE, 32'h0}, 12'h000, "add_stall");
        step(1, ADD123, 0, 1, 1, 5'd5, 32'h55, 1, 48'h0, 96'h0, 12'h000, "reset_mid");
        step(0, ADD123, 0, 0, 0, 0, 0, 0, f_add, 96'h0, 12'h212, "rd_after_rst");

        @(negedge clk);
        i_we = 1'b0; i_we_wb = 1'b0; i_stall = 1'b0;
        for (int i = 0; i < 20 && q_f.size() > 0; i++) @(negedge clk);
        n_cmp++;
        if (q_f.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending want 0", q_f.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
